// File: rtl/iter_mul_unit.sv
// -----------------------------------------------------------------------------
// iter_mul_unit
//
// Iterative shift-add multiplier with val/rdy handshakes on both sides. Signs
// are stripped up front, then one multiplier bit is consumed per cycle, and the
// sign is re-applied to the 2N-bit product on the way out. Each request returns
// either the low half or the high half of the product.
//
// Parameters
//   p_nbits       operand / result width N (N >= 4)
//   p_early_exit  1 = stop once the remaining multiplier bits are all zero
//
// Ports
//   clk             clock
//   rst             synchronous active-high reset
//   istream_val     request valid
//   istream_rdy     unit can accept a request (IDLE only)
//   istream_op      0 MUL (low), 1 MULH (s x s), 2 MULHSU (s x u), 3 MULHU (u x u)
//   istream_in0     multiplicand
//   istream_in1     multiplier
//   ostream_val     result valid (DONE only)
//   ostream_rdy     consumer takes the result
//   ostream_result  selected half of the 2N-bit product
// -----------------------------------------------------------------------------
module iter_mul_unit #(
  parameter int p_nbits      = 32,
  parameter bit p_early_exit = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [1:0]         istream_op,
  input  logic [p_nbits-1:0] istream_in0,
  input  logic [p_nbits-1:0] istream_in1,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [p_nbits-1:0] ostream_result
);

  localparam int N  = p_nbits;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;

  localparam logic [N-1:0]   ONE_N   = 1;
  localparam logic [2*N-1:0] ONE_2N  = 1;
  localparam logic [CW-1:0]  ONE_CW  = 1;
  localparam logic [CW-1:0]  COUNT_N = CW'(N);

  logic [1:0]     state_q, state_d;
  logic [2*N-1:0] a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  count_q, count_d;
  logic [1:0]     op_q, op_d;
  logic           neg_q, neg_d;

  // Sign handling for the incoming request. The most-negative input negates
  // to itself, which read as unsigned is exactly the magnitude 2^(N-1).
  logic           sign0, sign1;
  logic [N-1:0]   mag0, mag1;

  assign sign0 = istream_in0[N-1] & ((istream_op == OP_MULH) | (istream_op == OP_MULHSU));
  assign sign1 = istream_in1[N-1] & (istream_op == OP_MULH);
  assign mag0  = sign0 ? (~istream_in0 + ONE_N) : istream_in0;
  assign mag1  = sign1 ? (~istream_in1 + ONE_N) : istream_in1;

  assign istream_rdy = (state_q == S_IDLE) & ~rst;
  assign ostream_val = (state_q == S_DONE) & ~rst;

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    count_d = count_q;
    op_d    = op_q;
    neg_d   = neg_q;

    case (state_q)
      S_IDLE: begin
        if (istream_val && istream_rdy) begin
          a_d     = {{N{1'b0}}, mag0};
          b_d     = mag1;
          acc_d   = '0;
          count_d = '0;
          op_d    = istream_op;
          neg_d   = sign0 ^ sign1;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d     = a_q << 1;
        b_d     = b_q >> 1;
        count_d = count_q + ONE_CW;
        // Decision uses post-shift b, so a zero multiplier still takes one pass.
        if ((count_d == COUNT_N) || (p_early_exit && (b_d == '0)))
          state_d = S_DONE;
      end

      S_DONE: begin
        if (ostream_rdy) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  // NOTE: the datapath registers are reset too, so the result port reads zero
  // straight out of reset rather than stale or unknown data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
    end
  end

  // Re-apply the sign to the full 2N-bit product, then pick the requested half.
  logic [2*N-1:0] product;

  assign product        = neg_q ? (~acc_q + ONE_2N) : acc_q;
  assign ostream_result = (op_q == OP_MUL) ? product[N-1:0] : product[2*N-1:N];

endmodule

// File: tb/tb_iter_mul_unit.sv
// -----------------------------------------------------------------------------
// tb_iter_mul_unit
//
// Directed bench for iter_mul_unit at N=32. Unit 0 runs the full N iterations,
// unit 1 has early exit enabled. Each unit has its own handshake signals; the
// reset is shared. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_iter_mul_unit;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;
  localparam logic [1:0] OP_MULHU  = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ival [2];
  logic        irdy [2];
  logic [1:0]  iop  [2];
  logic [31:0] in0  [2];
  logic [31:0] in1  [2];
  logic        oval [2];
  logic        ordy [2];
  logic [31:0] res  [2];

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  iter_mul_unit #(.p_nbits(32), .p_early_exit(1'b0)) u_full (
    .clk(clk), .rst(rst),
    .istream_val(ival[0]), .istream_rdy(irdy[0]), .istream_op(iop[0]),
    .istream_in0(in0[0]), .istream_in1(in1[0]),
    .ostream_val(oval[0]), .ostream_rdy(ordy[0]), .ostream_result(res[0])
  );

  iter_mul_unit #(.p_nbits(32), .p_early_exit(1'b1)) u_early (
    .clk(clk), .rst(rst),
    .istream_val(ival[1]), .istream_rdy(irdy[1]), .istream_op(iop[1]),
    .istream_in0(in0[1]), .istream_in1(in1[1]),
    .ostream_val(oval[1]), .ostream_rdy(ordy[1]), .ostream_result(res[1])
  );

  // Present one request on unit u, wait for the result, check latency
  // (counted from the accept cycle; lat=0 skips that check) and value, then
  // consume it and confirm the unit is back in IDLE the following cycle.
  task automatic do_op(input int u, input logic [1:0] op, input logic [31:0] x,
                       input logic [31:0] y, input int lat, input logic [31:0] exp,
                       input string nm);
    int n;
    bit rdy_seen;
    @(negedge clk);
    ival[u] = 1'b1; iop[u] = op; in0[u] = x; in1[u] = y;
    vecs++;
    if (irdy[u] !== 1'b1) begin
      errs++; $display("FAIL %s idle_rdy: got %b want 1", nm, irdy[u]);
    end
    @(posedge clk);
    @(negedge clk);
    ival[u] = 1'b0;
    n = 1;
    rdy_seen = 1'b0;
    while (oval[u] !== 1'b1 && n < 100) begin
      if (irdy[u] !== 1'b0) rdy_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    vecs++;
    if (oval[u] !== 1'b1) begin
      errs++; $display("FAIL %s timeout: no ostream_val after %0d cycles", nm, n);
      return;
    end
    if (lat != 0) begin
      vecs++;
      if (n != lat) begin
        errs++; $display("FAIL %s latency: got c+%0d want c+%0d", nm, n, lat);
      end
    end
    vecs++;
    if (rdy_seen || irdy[u] !== 1'b0) begin
      errs++; $display("FAIL %s busy_rdy: istream_rdy high while busy (now %b)", nm, irdy[u]);
    end
    vecs++;
    if (res[u] !== exp) begin
      errs++; $display("FAIL %s result: got %h want %h", nm, res[u], exp);
    end
    ordy[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[u] = 1'b0;
    vecs++;
    if (oval[u] !== 1'b0 || irdy[u] !== 1'b1) begin
      errs++; $display("FAIL %s post_consume: val=%b rdy=%b want val=0 rdy=1", nm, oval[u], irdy[u]);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      vecs++;
      if (irdy[u] !== 1'b0 || oval[u] !== 1'b0) begin
        errs++; $display("FAIL reset_hold u%0d: rdy=%b val=%b want 0 0", u, irdy[u], oval[u]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      vecs++;
      if (res[u] !== 32'h0 || irdy[u] !== 1'b1 || oval[u] !== 1'b0) begin
        errs++; $display("FAIL reset_out u%0d: res=%h rdy=%b val=%b want 0 1 0",
                         u, res[u], irdy[u], oval[u]);
      end
    end
  endtask

  task automatic test_basic_mul();
    do_op(0, OP_MUL, 32'd7, 32'd6, 33, 32'd42, "mul_7x6");
  endtask

  task automatic test_signed_modes();
    do_op(0, OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0001, "mul_m1");
    do_op(0, OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0000, "mulh_m1");
    do_op(0, OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, "mulhu_max");
    do_op(0, OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         33, 32'hFFFF_FFFF, "mulhsu_m1x2");
    do_op(0, OP_MULH,   32'hFFFF_FFFD, 32'd5,         33, 32'hFFFF_FFFF, "mulh_m3x5");
  endtask

  task automatic test_most_negative();
    do_op(0, OP_MULH, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, "mulh_minneg");
    do_op(0, OP_MUL,  32'h8000_0000, 32'h8000_0000, 33, 32'h0000_0000, "mul_minneg");
  endtask

  task automatic test_back_pressure();
    logic [31:0] held;
    int n;
    @(negedge clk);
    ival[0] = 1'b1; iop[0] = OP_MUL; in0[0] = 32'h10; in1[0] = 32'h20;
    @(posedge clk);
    @(negedge clk);
    ival[0] = 1'b0;
    n = 1;
    while (oval[0] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    held = res[0];
    vecs++;
    if (oval[0] !== 1'b1 || held !== 32'h200) begin
      errs++; $display("FAIL bp_first: val=%b res=%h want 1 00000200", oval[0], held);
    end
    for (int i = 0; i < 5; i++) begin
      ival[0] = (i == 2);
      iop[0]  = OP_MUL; in0[0] = 32'd9; in1[0] = 32'd9;
      @(negedge clk);
      vecs++;
      if (oval[0] !== 1'b1 || res[0] !== held || irdy[0] !== 1'b0) begin
        errs++; $display("FAIL bp_hold%0d: val=%b res=%h rdy=%b want 1 %h 0",
                         i, oval[0], res[0], irdy[0], held);
      end
    end
    ival[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[0] = 1'b0;
    vecs++;
    if (irdy[0] !== 1'b1 || oval[0] !== 1'b0) begin
      errs++; $display("FAIL bp_release: rdy=%b val=%b want 1 0", irdy[0], oval[0]);
    end
    repeat (3) @(negedge clk);
    vecs++;
    if (irdy[0] !== 1'b1 || oval[0] !== 1'b0) begin
      errs++; $display("FAIL bp_no_accept: rdy=%b val=%b want 1 0", irdy[0], oval[0]);
    end
  endtask

  task automatic test_early_exit();
    do_op(1, OP_MUL,   32'd5,         32'd3,         3,  32'd15,        "ee_in1_3");
    do_op(1, OP_MUL,   32'h1234,      32'd0,         2,  32'd0,         "ee_in1_0");
    do_op(1, OP_MULHU, 32'd2,         32'h8000_0000, 33, 32'd1,         "ee_in1_msb");
    do_op(1, OP_MUL,   32'hFFFF_FFFD, 32'd5,         4,  32'hFFFF_FFF1, "ee_mul_m3x5");
    do_op(1, OP_MULH,  32'd7,         32'hFFFF_FFFE, 3,  32'hFFFF_FFFF, "ee_mulh_7xm2");
  endtask

  task automatic test_reset_mid_calc();
    bit seen;
    @(negedge clk);
    ival[0] = 1'b1; iop[0] = OP_MUL; in0[0] = 32'h1234; in1[0] = 32'h5678;
    @(posedge clk);
    @(negedge clk);
    ival[0] = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    vecs++;
    if (irdy[0] !== 1'b0 || oval[0] !== 1'b0) begin
      errs++; $display("FAIL rst_calc_hold: rdy=%b val=%b want 0 0", irdy[0], oval[0]);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    vecs++;
    if (irdy[0] !== 1'b1 || oval[0] !== 1'b0 || res[0] !== 32'h0) begin
      errs++; $display("FAIL rst_calc_idle: rdy=%b val=%b res=%h want 1 0 0",
                       irdy[0], oval[0], res[0]);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (oval[0] !== 1'b0) seen = 1'b1;
    end
    vecs++;
    if (seen) begin
      errs++; $display("FAIL rst_calc_no_result: ostream_val rose after reset, want 0");
    end
    do_op(0, OP_MUL, 32'd3, 32'd5, 33, 32'd15, "post_rst_3x5");
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      ival[u] = 1'b0; iop[u] = OP_MUL; in0[u] = '0; in1[u] = '0; ordy[u] = 1'b0;
    end
    test_reset();
    test_basic_mul();
    test_signed_modes();
    test_most_negative();
    test_back_pressure();
    test_early_exit();
    test_reset_mid_calc();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/iter_mul_unit.md
Name: iter_mul_unit

Overview:
- Iterative shift-add multiply unit with val/rdy streams on input and output.
- Replaces the combinational multiplier in the next-generation processor datapath. It is sized for an X-stage variable-latency functional unit.
- Parametrised in operand width and early-termination mode.
- Supports low-product and high-product operations with signed, unsigned and mixed operand signedness.

Parameters:
p_nbits, 32, operand and result width N (N >= 4)
p_early_exit, 0, 1 = stop iterating once the remaining multiplier bits are all zero

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
istream_val  input  1  request valid
istream_rdy  output  1  unit can accept a request
istream_op  input  2  0=MUL (low N bits), 1=MULH (signed x signed, high), 2=MULHSU (signed x unsigned, high), 3=MULHU (unsigned x unsigned, high)
istream_in0  input  N  multiplicand
istream_in1  input  N  multiplier
ostream_val  output  1  result valid
ostream_rdy  input  1  consumer can take result
ostream_result  output  N  selected half of the 2N-bit product

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- States: IDLE, CALC, DONE.
- Reset:
  - Next edge with rst=1 sets state to IDLE and clears all datapath registers.
  - While rst=1, istream_rdy=0 and ostream_val=0.
  - ostream_result=0 out of reset.
- IDLE:
  - istream_rdy=1, ostream_val=0.
  - Accept occurs when istream_val & istream_rdy at a clock edge. On accept, load:
    - a = |in0| zero-extended to 2N bits
    - b = |in1| (N bits)
    - acc = 0
    - count = 0
    - op
    - neg flag
  - Then go to CALC.
- Absolute value and negation rules:
  - in0 is negated only if op is MULH or MULHSU and in0[N-1]=1.
  - in1 is negated only if op is MULH and in1[N-1]=1.
  - The most-negative value maps to 2^(N-1) as an unsigned magnitude, which is legal.
  - MUL uses unsigned magnitudes because the low half is sign-independent.
  - neg = (sign of in0 used) XOR (sign of in1 used).
- CALC (one iteration per cycle):
  - If b[0]=1, acc += a.
  - a <<= 1, b >>= 1, count++.
  - istream_rdy=0, ostream_val=0.
  - Exit to DONE after the iteration where count reaches N.
  - If p_early_exit=1, also exit after any iteration whose post-shift b == 0.
  - There is always at least one iteration.
- DONE:
  - ostream_val=1, istream_rdy=0.
  - Let p = neg ? (~acc + 1) : acc, a 2N-bit two's complement value.
  - ostream_result = p[N-1:0] for MUL, and p[2N-1:N] otherwise.
  - Output is held stable until ostream_rdy=1 at an edge, then go to IDLE.
  - A new request is never accepted in the same cycle that a result is consumed. There is a one-cycle IDLE gap.
- Latency:
  - With an accept in cycle c and p_early_exit=0, ostream_val=1 from cycle c+N+1.
  - With p_early_exit=1, ostream_val=1 from cycle c+k+1, where k = max(1, position of the highest set bit of |in1| + 1).
- Boundaries:
  - Back-pressure in DONE is unbounded; ostream_result must not change.
  - istream_val toggling while not in IDLE is ignored.
  - Reset in CALC or DONE abandons the operation; no result is emitted.
  - The adder is 2N bits wide; carry out of bit 2N-1 is discarded and cannot occur for legal magnitudes.

Test Plan:
1. N=32, early_exit=0: MUL 7 x 6, accept in cycle c -> ostream_val first high in cycle c+33, result 42. istream_rdy is 0 in cycles c+1..c+33 and 1 again in c+34 after consumption.
2. Signed modes with in0=in1=0xFFFFFFFF:
   - MUL -> 0x00000001
   - MULH -> 0x00000000
   - MULHU -> 0xFFFFFFFE
   - MULHSU with in0=0xFFFFFFFF, in1=2 -> 0xFFFFFFFF
3. Most-negative operands: MULH 0x80000000 x 0x80000000 -> 0x40000000; MUL with the same operands -> 0x00000000.
4. Back-pressure: hold ostream_rdy=0 for 5 cycles in DONE -> ostream_val stays 1, ostream_result constant, istream_rdy stays 0, and an istream_val pulse is not accepted. Raise ostream_rdy -> next cycle is IDLE with istream_rdy=1.
5. early_exit=1:
   - in1=3 -> result valid in cycle c+3
   - in1=0 -> valid in cycle c+2 with result 0
   - in1=0x80000000 (MULHU, in0=2) -> valid in cycle c+33 with result 1
6. Reset: assert rst for one cycle in the 10th CALC cycle -> next cycle is IDLE with ostream_val=0 and no result. A fresh MUL 3 x 5 afterwards -> 15.
